// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer. Owns the fetch PC, drives the instruction
// memory request/address handshake, arbitrates next-PC sources and drops any
// response that a redirect made stale.
// Optional feature macro: FETCH_PERF_CNT_EN (redirect / ID-stall counters).
module fetch_ctrl #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] START_ADDR = 32'h1c00_0000
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              redir_ex_valid_i,
  input  logic [ADDR_W-1:0] redir_ex_pc_i,
  input  logic              redir_id_valid_i,
  input  logic [ADDR_W-1:0] redir_id_pc_i,
  output logic [ADDR_W-1:0] pred_pc_o,
  input  logic              pred_taken_i,
  input  logic [ADDR_W-1:0] pred_target_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_addr_ok_i,
  input  logic              imem_data_ok_i,
  input  logic [31:0]       imem_rdata_i,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [31:0]       if_inst_o,
  input  logic              id_allow_in_i
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_redir_cnt_o,
  output logic [31:0]       perf_stall_cnt_o
`endif
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(32'd4);

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] pend_pc, pend_pc_nxt;
  logic [ADDR_W-1:0] inst_pc, inst_pc_nxt;
  logic [31:0]       inst, inst_nxt;
  logic              discard, discard_nxt;
  logic              redir_pend, redir_pend_nxt;
  logic              req;
  logic              valid;

  logic              redir_v;
  logic [ADDR_W-1:0] redir_tgt;
  logic [ADDR_W-1:0] seq_pc;
  logic              accept;

  // EX beats ID when both redirect in the same cycle.
  assign redir_v   = redir_ex_valid_i | redir_id_valid_i;
  assign redir_tgt = redir_ex_valid_i ? redir_ex_pc_i : redir_id_pc_i;
  // Sequential path wraps silently at 2^ADDR_W; low PC bits are not touched.
  assign seq_pc    = pred_taken_i ? pred_target_i : (pc + PC_STEP);
  assign accept    = req & imem_addr_ok_i;

  assign pred_pc_o   = pc;
  assign imem_addr_o = pc;
  assign imem_req_o  = req;
  assign if_valid_o  = valid;
  assign if_pc_o     = inst_pc;
  assign if_inst_o   = inst;

  // Next-state, next-PC, stale-response and capture decisions.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    discard_nxt    = discard;
    redir_pend_nxt = redir_pend;
    pend_pc_nxt    = pend_pc;
    inst_pc_nxt    = inst_pc;
    inst_nxt       = inst;
    case (state)
      S_REQ: begin
        if (accept) begin
          state_nxt = S_WAIT;
          if (redir_v) begin
            // Request already accepted: its response becomes stale.
            discard_nxt    = 1'b1;
            pc_nxt         = redir_tgt;
            redir_pend_nxt = 1'b0;
          end else if (redir_pend) begin
            discard_nxt    = 1'b1;
            pc_nxt         = pend_pc;
            redir_pend_nxt = 1'b0;
          end else begin
            discard_nxt = 1'b0;
          end
        end else if (redir_v) begin
          // Address must stay stable until accepted; remember the target.
          redir_pend_nxt = 1'b1;
          pend_pc_nxt    = redir_tgt;
        end else begin
          state_nxt = S_REQ;
        end
      end
      S_WAIT: begin
        if (imem_data_ok_i) begin
          discard_nxt = 1'b0;
          if (redir_v) begin
            pc_nxt    = redir_tgt;
            state_nxt = S_REQ;
          end else if (discard) begin
            state_nxt = S_REQ;
          end else begin
            state_nxt   = S_HOLD;
            inst_pc_nxt = pc;
            inst_nxt    = imem_rdata_i;
          end
        end else if (redir_v) begin
          discard_nxt = 1'b1;
          pc_nxt      = redir_tgt;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_HOLD: begin
        if (redir_v) begin
          // Held instruction is wrong-path: drop it without a handshake.
          pc_nxt    = redir_tgt;
          state_nxt = S_REQ;
        end else if (id_allow_in_i) begin
          pc_nxt         = redir_pend ? pend_pc : seq_pc;
          redir_pend_nxt = 1'b0;
          state_nxt      = S_REQ;
        end else begin
          state_nxt = S_HOLD;
        end
      end
      default: begin
        state_nxt      = S_REQ;
        discard_nxt    = 1'b0;
        redir_pend_nxt = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered handshake outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= S_REQ;
      pc         <= START_ADDR;
      pend_pc    <= {ADDR_W{1'b0}};
      inst_pc    <= {ADDR_W{1'b0}};
      inst       <= 32'h0000_0000;
      discard    <= 1'b0;
      redir_pend <= 1'b0;
      req        <= 1'b0;
      valid      <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      pend_pc    <= pend_pc_nxt;
      inst_pc    <= inst_pc_nxt;
      inst       <= inst_nxt;
      discard    <= discard_nxt;
      redir_pend <= redir_pend_nxt;
      req        <= (state_nxt == S_REQ);
      valid      <= (state_nxt == S_HOLD);
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating counters: redirect cycles and ID back-pressure cycles in S_HOLD.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      perf_redir_cnt_o <= 32'h0000_0000;
      perf_stall_cnt_o <= 32'h0000_0000;
    end else begin
      if (redir_v && (perf_redir_cnt_o != 32'hFFFF_FFFF)) begin
        perf_redir_cnt_o <= perf_redir_cnt_o + 32'd1;
      end
      if ((state == S_HOLD) && !id_allow_in_i && (perf_stall_cnt_o != 32'hFFFF_FFFF)) begin
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level fetch model kept in the bench.
module tb_fetch_ctrl;

  localparam logic [31:0] START    = 32'h1c00_0000;
  localparam int          PH_ISSUE = 0;
  localparam int          PH_AWAIT = 1;
  localparam int          PH_HOLD  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_v = 1'b0, id_v = 1'b0, taken = 1'b0;
  logic        addr_ok = 1'b0, data_ok = 1'b0, allow = 1'b0;
  logic [31:0] ex_pc = 32'h0, id_pc = 32'h0, tgt = 32'h0, rdata = 32'h0;
  logic [31:0] pred_pc, addr, if_pc, if_inst;
  logic        req, if_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redir, perf_stall;
  logic [31:0] m_perf_redir, m_perf_stall;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // model of the fetch unit: current fetch address and transaction phase
  logic [31:0] m_pc, m_pend_pc, m_if_pc, m_if_inst;
  int          m_phase;
  bit          m_req, m_stale, m_pend_v;

  // memory model: at most one outstanding read
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_word;

  // stimulus controls
  bit          rand_mode, d_allow, pred_rule;
  int          ack_pct, fix_lat, ack_block;
  logic [31:0] pred_at, pred_to;
  int          trig_kind, trig_block;
  logic [31:0] trig_pc, trig_ex_pc, trig_id_pc;
  bit          trig_ex_v, trig_id_v, trig_fired;
  logic [31:0] acc_log[$];
  logic [31:0] deliv_log[$];
  logic [31:0] stall_addrs[$];

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .redir_ex_valid_i (ex_v),
    .redir_ex_pc_i    (ex_pc),
    .redir_id_valid_i (id_v),
    .redir_id_pc_i    (id_pc),
    .pred_pc_o        (pred_pc),
    .pred_taken_i     (taken),
    .pred_target_i    (tgt),
    .imem_req_o       (req),
    .imem_addr_o      (addr),
    .imem_addr_ok_i   (addr_ok),
    .imem_data_ok_i   (data_ok),
    .imem_rdata_i     (rdata),
    .if_valid_o       (if_valid),
    .if_pc_o          (if_pc),
    .if_inst_o        (if_inst),
    .id_allow_in_i    (allow)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_redir_cnt_o (perf_redir),
    .perf_stall_cnt_o (perf_stall)
`endif
  );

  function automatic void chk32(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: actual %h required %h", name, $time, act, exp);
    end
  endfunction

  function automatic void chk1(string name, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: actual %b required %b", name, $time, act, exp);
    end
  endfunction

  // choose this cycle's inputs (called just after a falling edge)
  task automatic drive_inputs();
    ex_v  = 1'b0;
    id_v  = 1'b0;
    ex_pc = $urandom;
    id_pc = $urandom;
    taken = 1'b0;
    tgt   = $urandom;
    allow = d_allow;
    if (rand_mode) begin
      ex_v  = ($urandom_range(99) < 4);
      id_v  = ($urandom_range(99) < 7);
      taken = 1'($urandom_range(1));
      tgt   = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : $urandom;
      allow = ($urandom_range(99) < 70);
    end
    if (pred_rule && m_phase == PH_HOLD && m_pc == pred_at) begin
      taken = 1'b1;
      tgt   = pred_to;
    end
    if (trig_kind != 0 && !trig_fired && m_phase == trig_kind - 1 && m_pc == trig_pc &&
        (trig_kind != 1 || m_req)) begin
      ex_v       = trig_ex_v;
      ex_pc      = trig_ex_pc;
      id_v       = trig_id_v;
      id_pc      = trig_id_pc;
      ack_block  = trig_block;
      trig_fired = 1'b1;
    end
    addr_ok = 1'b0;
    if (ack_block > 0) ack_block--;
    else addr_ok = m_req && ($urandom_range(99) < 32'(ack_pct));
    data_ok = mem_busy && mem_cnt == 0;
    rdata   = data_ok ? mem_word : $urandom;
  endtask

  // record accepted addresses, stalled request addresses and ID handshakes
  task automatic log_cycle();
    if (req && addr_ok) acc_log.push_back(addr);
    if (req && !addr_ok) stall_addrs.push_back(addr);
    if (if_valid && allow && !ex_v && !id_v) deliv_log.push_back(if_pc);
  endtask

  // advance the model by one clock using the inputs of the cycle just ended
  task automatic model_update();
    bit          rv, acc;
    logic [31:0] rt;
    rv  = ex_v || id_v;
    rt  = ex_v ? ex_pc : id_pc;
    acc = m_req && addr_ok;
`ifdef FETCH_PERF_CNT_EN
    if (rv && m_perf_redir != 32'hFFFF_FFFF) m_perf_redir++;
    if (m_phase == PH_HOLD && !allow && m_perf_stall != 32'hFFFF_FFFF) m_perf_stall++;
`endif
    if (data_ok) mem_busy = 1'b0;
    if (acc) begin
      mem_busy = 1'b1;
      mem_cnt  = (fix_lat > 0 ? fix_lat : int'($urandom_range(3, 1))) - 1;
      mem_word = $urandom;
    end else if (mem_busy && mem_cnt > 0) begin
      mem_cnt--;
    end
    if (m_phase == PH_ISSUE) begin
      if (acc) begin
        m_phase = PH_AWAIT;
        if (rv) begin
          m_stale = 1'b1; m_pc = rt; m_pend_v = 1'b0;
        end else if (m_pend_v) begin
          m_stale = 1'b1; m_pc = m_pend_pc; m_pend_v = 1'b0;
        end
      end else if (rv) begin
        m_pend_v  = 1'b1;
        m_pend_pc = rt;
      end
    end else if (m_phase == PH_AWAIT) begin
      if (data_ok) begin
        if (rv) begin
          m_pc = rt; m_phase = PH_ISSUE;
        end else if (m_stale) begin
          m_phase = PH_ISSUE;
        end else begin
          m_phase = PH_HOLD; m_if_pc = m_pc; m_if_inst = rdata;
        end
        m_stale = 1'b0;
      end else if (rv) begin
        m_stale = 1'b1;
        m_pc    = rt;
      end
    end else begin
      if (rv) begin
        m_pc = rt; m_phase = PH_ISSUE;
      end else if (allow) begin
        m_pc     = m_pend_v ? m_pend_pc : (taken ? tgt : m_pc + 32'd4);
        m_pend_v = 1'b0;
        m_phase  = PH_ISSUE;
      end
    end
    m_req = (m_phase == PH_ISSUE);
  endtask

  task automatic compare_outputs();
    chk1 ("imem_req",  req, m_req);
    chk32("pred_pc",   pred_pc, m_pc);
    chk32("imem_addr", addr, m_pc);
    chk1 ("if_valid",  if_valid, m_phase == PH_HOLD);
    chk32("if_pc",     if_pc, m_if_pc);
    chk32("if_inst",   if_inst, m_if_inst);
`ifdef FETCH_PERF_CNT_EN
    chk32("perf_redir", perf_redir, m_perf_redir);
    chk32("perf_stall", perf_stall, m_perf_stall);
`endif
  endtask

  task automatic step();
    drive_inputs();
    log_cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ex_v = 1'b0; id_v = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; allow = 1'b0; taken = 1'b0;
    #1;
    chk1 ("rst_req",     req, 1'b0);
    chk1 ("rst_valid",   if_valid, 1'b0);
    chk32("rst_if_pc",   if_pc, 32'h0);
    chk32("rst_if_inst", if_inst, 32'h0);
    chk32("rst_addr",    addr, START);
    chk32("rst_pred_pc", pred_pc, START);
`ifdef FETCH_PERF_CNT_EN
    chk32("rst_perf_redir", perf_redir, 32'h0);
    chk32("rst_perf_stall", perf_stall, 32'h0);
    m_perf_redir = 32'h0;
    m_perf_stall = 32'h0;
`endif
    m_pc = START; m_phase = PH_ISSUE; m_req = 1'b0; m_stale = 1'b0; m_pend_v = 1'b0;
    m_pend_pc = 32'h0; m_if_pc = 32'h0; m_if_inst = 32'h0;
    mem_busy = 1'b0; mem_cnt = 0; ack_block = 0;
    trig_kind = 0; trig_fired = 1'b0; trig_block = 0; pred_rule = 1'b0;
    acc_log.delete(); deliv_log.delete(); stall_addrs.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until_acc(int n, int budget, string name);
    int c = 0;
    while (acc_log.size() < n && c < budget) begin step(); c++; end
    chk32(name, 32'(acc_log.size()), 32'(n));
  endtask

  task automatic run_until_deliv(int n, int budget, string name);
    int c = 0;
    while (deliv_log.size() < n && c < budget) begin step(); c++; end
    chk32(name, 32'(deliv_log.size()), 32'(n));
  endtask

  task automatic run_until_fired(int budget, string name);
    int c = 0;
    while (!trig_fired && c < budget) begin step(); c++; end
    chk1(name, trig_fired, 1'b1);
  endtask

  task automatic run_until_hold(int budget, string name);
    int c = 0;
    while (m_phase != PH_HOLD && c < budget) begin step(); c++; end
    chk1(name, m_phase == PH_HOLD, 1'b1);
  endtask

  initial begin
    rand_mode = 1'b0; d_allow = 1'b1; ack_pct = 100; fix_lat = 1;
    @(negedge clk);

    // D1: sequential fetch with single-cycle memory
    do_reset();
    run_until_acc(3, 40, "d1_accepts");
    chk32("d1_addr0", acc_log[0], 32'h1c00_0000);
    chk32("d1_addr1", acc_log[1], 32'h1c00_0004);
    chk32("d1_addr2", acc_log[2], 32'h1c00_0008);
    chk32("d1_deliv0", deliv_log[0], 32'h1c00_0000);
    chk32("d1_deliv1", deliv_log[1], 32'h1c00_0004);

    // D2: predictor taken at 1c000004
    do_reset();
    pred_rule = 1'b1; pred_at = 32'h1c00_0004; pred_to = 32'h1c00_0100;
    run_until_acc(3, 40, "d2_accepts");
    chk32("d2_pred_target", acc_log[2], 32'h1c00_0100);

    // D3: ID redirect while waiting for 1c000008
    do_reset();
    fix_lat = 2;
    trig_kind = 2; trig_pc = 32'h1c00_0008;
    trig_ex_v = 1'b0; trig_id_v = 1'b1; trig_id_pc = 32'h1c00_0200;
    run_until_acc(4, 60, "d3_accepts");
    chk32("d3_addr2", acc_log[2], 32'h1c00_0008);
    chk32("d3_addr3", acc_log[3], 32'h1c00_0200);
    run_until_deliv(3, 40, "d3_delivs");
    chk32("d3_deliv2", deliv_log[2], 32'h1c00_0200);

    // D4: EX and ID redirect together in S_HOLD
    do_reset();
    fix_lat = 1; d_allow = 1'b0;
    trig_kind = 3; trig_pc = 32'h1c00_0000;
    trig_ex_v = 1'b1; trig_ex_pc = 32'h1c00_0800; trig_id_v = 1'b1; trig_id_pc = 32'h1c00_0300;
    run_until_fired(40, "d4_fired");
    d_allow = 1'b1;
    run_until_acc(3, 40, "d4_accepts");
    chk32("d4_addr1", acc_log[1], 32'h1c00_0800);
    chk32("d4_addr2", acc_log[2], 32'h1c00_0804);
    chk32("d4_deliv0", deliv_log[0], 32'h1c00_0800);

    // D5: ID redirect in S_REQ with address accept held off 3 cycles
    do_reset();
    trig_kind = 1; trig_pc = 32'h1c00_0004; trig_block = 3;
    trig_ex_v = 1'b0; trig_id_v = 1'b1; trig_id_pc = 32'h1c00_0400;
    run_until_acc(3, 60, "d5_accepts");
    chk32("d5_addr1", acc_log[1], 32'h1c00_0004);
    chk32("d5_addr2", acc_log[2], 32'h1c00_0400);
    chk32("d5_stall_len", 32'(stall_addrs.size()), 32'd3);
    foreach (stall_addrs[i]) chk32("d5_stall_addr", stall_addrs[i], 32'h1c00_0004);
    run_until_deliv(2, 40, "d5_delivs");
    chk32("d5_deliv1", deliv_log[1], 32'h1c00_0400);

    // D6: ID back-pressure for 5 cycles
    do_reset();
    d_allow = 1'b0;
    run_until_hold(20, "d6_hold");
    for (int i = 0; i < 5; i++) begin
      step();
      chk1 ("d6_valid", if_valid, 1'b1);
      chk32("d6_if_pc", if_pc, 32'h1c00_0000);
      chk1 ("d6_no_req", req, 1'b0);
    end
`ifdef FETCH_PERF_CNT_EN
    chk32("d6_stall_cnt", perf_stall, 32'd5);
`endif
    d_allow = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // randomized traffic with occasional mid-flight reset
    rand_mode = 1'b1; ack_pct = 60; fix_lat = 0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step();
      if (i % 1300 == 1299) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch-stage sequencer that owns the architectural fetch PC and drives the instruction-memory request handshake. It arbitrates next-PC sources: EX-stage redirect (exception/ertn), ID-stage mispredict correction, predictor taken and sequential PC+4. It buffers the fetched instruction toward ID. It discards in-flight responses invalidated by a redirect, so the pipeline never receives a wrong-path instruction after a redirect.

Parameters:
ADDR_W, 32, width of PC and memory address
START_ADDR, 32'h1c00_0000, first PC fetched after reset

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
redir_ex_valid_i  in  1  EX redirect (exception/ertn), highest priority
redir_ex_pc_i  in  ADDR_W  EX redirect target
redir_id_valid_i  in  1  ID mispredict correction
redir_id_pc_i  in  ADDR_W  ID correction target
pred_pc_o  out  ADDR_W  PC presented to branch predictor (= current fetch PC)
pred_taken_i  in  1  predictor says taken for pred_pc_o
pred_target_i  in  ADDR_W  predicted target
imem_req_o  out  1  memory request valid
imem_addr_o  out  ADDR_W  request address
imem_addr_ok_i  in  1  request accepted
imem_data_ok_i  in  1  read data returned
imem_rdata_i  in  32  instruction word
if_valid_o  out  1  instruction valid to ID
if_pc_o  out  ADDR_W  PC of delivered instruction
if_inst_o  out  32  delivered instruction
id_allow_in_i  in  1  ID accepts this cycle

Behaviour:
- Reset (async assert, sync release): pc=START_ADDR, state=S_REQ, imem_req_o=0 in reset, if_valid_o=0, if_pc_o=0, if_inst_o=0, discard=0, redir_pend=0.
- States:
  - S_REQ: imem_req_o=1, imem_addr_o=pc; addr/req held stable until imem_addr_ok_i. On addr_ok, go to S_WAIT.
  - S_WAIT: wait for imem_data_ok_i. On data_ok with discard=0, go to S_HOLD and latch inst/pc. With discard=1, clear discard and go to S_REQ.
  - S_HOLD: if_valid_o=1. On id_allow_in_i, advance pc=next_pc and go to S_REQ.
- Fetch latency: minimum 1 cycle from REQ entry to addr_ok. Next REQ issues the cycle after HOLD handshake; one outstanding request max.
- next_pc priority:
  - redir_ex > redir_id > redir_pend > (pred_taken_i ? pred_target_i : pc+4).
  - pred sampled in S_HOLD at the handshake cycle.
  - pc+4 is modulo 2^ADDR_W and wraps silently.
- Redirect arrival by state:
  - S_HOLD: pc=target, if_valid_o drops next cycle, go to S_REQ (no handshake counted).
  - S_REQ before addr_ok: request is not withdrawn; target latched into redir_pend.
  - S_REQ same cycle as addr_ok: go to S_WAIT with discard=1, pc=target.
  - S_WAIT: set discard=1, pc=target.
  - data_ok in the same cycle as a redirect: response discarded, go to S_REQ with pc=target.
- redir_pend handling:
  - In S_REQ, when addr_ok arrives with redir_pend set: discard=1, pc=pending target, redir_pend cleared.
  - A newer redirect overwrites redir_pend; EX beats ID in the same cycle.
- Simultaneous redir_ex and redir_id: EX target used, ID dropped.
- pc[1:0] are carried unchanged; no alignment enforcement here.
- Reset mid-transaction: all state cleared immediately. A late data_ok after reset release is ignored unless in S_WAIT (cannot occur since S_REQ is entered first).

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs perf_redir_cnt_o[31:0] and perf_stall_cnt_o[31:0], both reset to 0, saturating at 32'hFFFF_FFFF.
  - perf_redir_cnt_o counts cycles with any redirect valid.
  - perf_stall_cnt_o counts S_HOLD cycles with id_allow_in_i=0.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset release, memory acks every request next cycle, id_allow_in_i=1 -> addresses 1c000000, 1c000004, 1c000008 issued; if_valid_o with matching if_pc_o.
- Hold at S_HOLD PC 1c000004, pred_taken_i=1, pred_target_i=1c000100 -> next imem_addr_o=1c000100.
- redir_id at 1c000200 during S_WAIT for 1c000008 -> returned word dropped (if_valid_o stays 0); next request 1c000200.
- redir_ex=1c000800 and redir_id=1c000300 same cycle in S_HOLD -> next request 1c000800; 1c000300 never issued.
- redir_id=1c000400 in S_REQ with addr_ok held low 3 cycles -> imem_addr_o stays old PC until accepted; that response discarded; then request 1c000400.
- id_allow_in_i=0 for 5 cycles in S_HOLD -> if_inst_o/if_pc_o stable, no new imem_req_o; with FETCH_PERF_CNT_EN perf_stall_cnt_o=5.
